// File: rtl/pp_norm_quant_stage_if.sv
// Purpose : FIFO-side handshake bundle of the normalise/quantise stage
//           (show-ahead pixel FIFO on the input, 3x int8 FIFO on the output).
// Ports   : master = stage side (pops input, pushes output); slave = FIFO side.
interface pp_norm_quant_stage_if;
    logic        in_empty_n;   // upstream FIFO has data, in_dout valid
    logic        in_read;      // pop upstream FIFO
    logic [31:0] in_dout;      // packed pixel, ch0 at [7:0], [31:24] unused
    logic        out_full_n;   // downstream FIFO has space
    logic        out_write;    // push downstream FIFO
    logic [23:0] out_din;      // packed 3x int8 result, ch0 at [7:0]

    modport master (
        input  in_empty_n,
        input  in_dout,
        input  out_full_n,
        output in_read,
        output out_write,
        output out_din
    );

    modport slave (
        output in_empty_n,
        output in_dout,
        output out_full_n,
        input  in_read,
        input  out_write,
        input  out_din
    );
endinterface

// File: rtl/pp_norm_quant_stage.sv
// Purpose : per-channel (pixel - mean) * scale, rounding arithmetic shift and
//           int8 saturation over one rows x cols frame per start pulse.
// Latency : pop at cycle t -> push at t+2 when unstalled, one pixel per cycle.
// Backpressure: out_full_n low with a result waiting freezes both stages and
//           stops popping; out_din stays stable until the push happens.
// Ports   : clk, reset (sync, active-high), start/rows/cols/cfg_mean/cfg_scale
//           config sampled on start, busy/done status, bus = FIFO handshakes.
module pp_norm_quant_stage #(
    parameter int DIM_W = 12,
    parameter int SHIFT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] rows,
    input  logic [DIM_W-1:0] cols,
    input  logic [23:0]      cfg_mean,
    input  logic [23:0]      cfg_scale,
    output logic             busy,
    output logic             done,
    pp_norm_quant_stage_if.master bus
);

    localparam int TOT_W = 2 * DIM_W;
    // Half-LSB rounding constant; SH1 keeps the shift amount legal when SHIFT==0.
    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [18:0] RND = (SHIFT > 0) ? (19'sd1 <<< SH1) : 19'sd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [TOT_W-1:0]   total;
    logic [TOT_W-1:0]   rd_left;
    logic [TOT_W-1:0]   wr_left;
    logic [23:0]        mean_q;
    logic [23:0]        scale_q;

    logic               launch;
    logic               adv;
    logic               rd;
    logic               wr;

    logic               s1_valid;
    logic signed [17:0] s1_p [3];
    logic               s2_valid;
    logic [23:0]        s2_dat;

    logic signed [8:0]  d_c   [3];
    logic signed [17:0] p_nxt [3];
    logic signed [18:0] sum_c [3];
    logic signed [18:0] r_c   [3];
    logic [23:0]        q_nxt;

    // The top byte of the pixel word carries nothing for this stage.
    logic               unused_hi;
    assign unused_hi = ^bus.in_dout[31:24];

    assign total  = TOT_W'(rows) * TOT_W'(cols);
    assign launch = (state == ST_IDLE) && start;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // An empty frame still produces its done pulse.
                    state_nxt = (total == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr && (wr_left == TOT_W'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Handshakes. Both strobes are masked by reset so that a reset landing
    // mid-frame can neither consume a pixel nor push a stale result.
    // ------------------------------------------------------------------
    assign adv = !s2_valid || bus.out_full_n;
    assign rd  = !reset && (state == ST_RUN) && (rd_left != '0) && bus.in_empty_n && adv;
    assign wr  = !reset && s2_valid && bus.out_full_n;

    assign bus.in_read   = rd;
    assign bus.out_write = wr;
    assign bus.out_din   = s2_dat;

    // ------------------------------------------------------------------
    // Config latch and frame counters (config only moves on an accepted start)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mean_q  <= '0;
            scale_q <= '0;
            rd_left <= '0;
            wr_left <= '0;
        end else if (launch) begin
            mean_q  <= cfg_mean;
            scale_q <= cfg_scale;
            rd_left <= total;
            wr_left <= total;
        end else begin
            if (rd) begin
                rd_left <= rd_left - TOT_W'(1);
            end
            if (wr) begin
                wr_left <= wr_left - TOT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // S1 datapath: zero-extend both bytes so the difference is 9-bit signed,
    // then multiply by the zero-extended scale into an 18-bit signed product.
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            d_c[c]   = $signed({1'b0, bus.in_dout[8*c +: 8]}) - $signed({1'b0, mean_q[8*c +: 8]});
            p_nxt[c] = 18'(d_c[c]) * 18'($signed({1'b0, scale_q[8*c +: 8]}));
        end
    end

    // ------------------------------------------------------------------
    // S2 datapath: round half up, arithmetic shift (floor), clamp to int8.
    // One extra bit of headroom keeps the rounding add from overflowing.
    // ------------------------------------------------------------------
    always_comb begin
        q_nxt = '0;
        for (int c = 0; c < 3; c++) begin
            sum_c[c] = 19'(s1_p[c]) + RND;
            r_c[c]   = sum_c[c] >>> SHIFT;
            if (r_c[c] > 19'sd127) begin
                q_nxt[8*c +: 8] = 8'h7F;
            end else if (r_c[c] < -19'sd128) begin
                q_nxt[8*c +: 8] = 8'h80;
            end else begin
                q_nxt[8*c +: 8] = r_c[c][7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: both stages move together on adv, otherwise hold.
    // S2 data only loads from a valid S1 so out_din never shows a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_dat   <= '0;
            for (int c = 0; c < 3; c++) begin
                s1_p[c] <= '0;
            end
        end else if (adv) begin
            s1_valid <= rd;
            s2_valid <= s1_valid;
            if (rd) begin
                for (int c = 0; c < 3; c++) begin
                    s1_p[c] <= p_nxt[c];
                end
            end
            if (s1_valid) begin
                s2_dat <= q_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pp_norm_quant_stage.sv
module tb_pp_norm_quant_stage;

    localparam int DIM_W = 12;
    localparam int SHIFT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DIM_W-1:0] rows;
    logic [DIM_W-1:0] cols;
    logic [23:0]      cfg_mean;
    logic [23:0]      cfg_scale;
    logic             busy;
    logic             done;

    pp_norm_quant_stage_if bus ();

    pp_norm_quant_stage #(
        .DIM_W (DIM_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rows      (rows),
        .cols      (cols),
        .cfg_mean  (cfg_mean),
        .cfg_scale (cfg_scale),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc         = 0;
    int pops        = 0;
    int writes      = 0;
    int done_cnt    = 0;
    int done_cyc    = -1;
    int last_wr_cyc = -1;
    int start_cyc   = -1;
    int empty_mode  = 0;   // 0: source ready whenever it holds data, 1: random gaps
    int full_mode   = 0;   // 0: sink always ready, 1: random, 2: toggles every 3 cycles

    logic [31:0] src_q [$];
    logic [23:0] exp_q [$];
    logic [23:0] m_mean;
    logic [23:0] m_scale;
    logic [23:0] last_wr_dat;

    typedef struct {
        logic [31:0] pix;
        logic [23:0] mean;
        logic [23:0] scale;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: plain integer arithmetic, floor division for the shift.
    function automatic int floor_div(input int v, input int d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic logic [23:0] model(input logic [31:0] pix, input logic [23:0] mean,
                                          input logic [23:0] scale);
        logic [23:0] res;
        int          rnd;
        res = '0;
        rnd = (SHIFT > 0) ? (2 ** (SHIFT - 1)) : 0;
        for (int c = 0; c < 3; c++) begin
            int d;
            int r;
            d = int'(pix[8*c +: 8]) - int'(mean[8*c +: 8]);
            r = floor_div(d * int'(scale[8*c +: 8]) + rnd, 2 ** SHIFT);
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
            res[8*c +: 8] = r[7:0];
        end
        return res;
    endfunction

    // FIFO models + monitor. Each negedge: account for what the previous
    // posedge committed, drive new FIFO-side inputs, then sample what the
    // coming posedge will commit.
    initial begin
        logic        o_rd;
        logic        o_wr;
        logic        o_rst;
        logic [23:0] o_din;
        logic [31:0] pix;
        o_rd  = 1'b0;
        o_wr  = 1'b0;
        o_rst = 1'b1;
        o_din = '0;
        bus.in_empty_n = 1'b0;
        bus.in_dout    = '0;
        bus.out_full_n = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!o_rst) begin
                if (o_rd) begin
                    pops++;
                    if (src_q.size() == 0) begin
                        fail("pop_from_empty_source");
                    end else begin
                        pix = src_q.pop_front();
                        exp_q.push_back(model(pix, m_mean, m_scale));
                    end
                end
                if (o_wr) begin
                    writes++;
                    last_wr_dat = o_din;
                    if (exp_q.size() == 0) fail("spurious_write");
                    else check("out_din", {8'h0, o_din}, {8'h0, exp_q.pop_front()});
                end
            end
            bus.in_empty_n = (src_q.size() > 0) && (empty_mode == 0 || $urandom_range(0, 3) != 0);
            bus.in_dout    = (src_q.size() > 0) ? src_q[0] : $urandom();
            if (full_mode == 0)      bus.out_full_n = 1'b1;
            else if (full_mode == 1) bus.out_full_n = ($urandom_range(0, 3) != 0);
            else                     bus.out_full_n = (((cyc / 3) % 2) == 1);
            #1;
            o_rd  = bus.in_read;
            o_wr  = bus.out_write;
            o_din = bus.out_din;
            o_rst = reset;
            if (o_rd) check("read_needs_data", {31'b0, bus.in_empty_n}, 32'd1);
            if (o_wr) check("write_needs_space", {31'b0, bus.out_full_n}, 32'd1);
            // Two results in flight means S1 and S2 are both full: a stall
            // must freeze popping and present the oldest pending result.
            if (!reset && !bus.out_full_n && exp_q.size() == 2) begin
                check("stall_no_read", {31'b0, o_rd}, 32'd0);
                check("stall_din_held", {8'h0, o_din}, {8'h0, exp_q[0]});
            end
            if (done)  begin done_cnt++; done_cyc = cyc; end
            if (o_wr)  last_wr_cyc = cyc;
            if (start) start_cyc = cyc;
        end
    end

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            #3;
        end
    endtask

    task automatic start_frame(input int r, input int c, input logic [23:0] mean,
                               input logic [23:0] scale);
        @(negedge clk);
        rows      = DIM_W'(r);
        cols      = DIM_W'(c);
        cfg_mean  = mean;
        cfg_scale = scale;
        m_mean    = mean;
        m_scale   = scale;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int k;
        k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (done_cnt == base) fail("done_timeout");
    endtask

    task automatic run_frame(input int r, input int c, input logic [23:0] mean,
                             input logic [23:0] scale, input string tag);
        int p0;
        int w0;
        int d0;
        p0 = pops;
        w0 = writes;
        d0 = done_cnt;
        start_frame(r, c, mean, scale);
        wait_done(d0, 4000);
        settle(3);
        check({tag, "_pops"},   pops - p0,     r * c);
        check({tag, "_writes"}, writes - w0,   r * c);
        check({tag, "_dones"},  done_cnt - d0, 1);
        check({tag, "_drain"},  exp_q.size(),  0);
    endtask

    initial begin
        int p0;
        int w0;
        int d0;
        int k;

        vecs[0] = '{pix: 32'h0080_6040, mean: 24'h000000, scale: 24'h010101, exp: 24'h010000};
        vecs[1] = '{pix: 32'h0000_0000, mean: 24'h0000FF, scale: 24'h0000FF, exp: 24'h000080};
        vecs[2] = '{pix: 32'h00FF_FFFF, mean: 24'h000000, scale: 24'hFFFFFF, exp: 24'h7F7F7F};
        vecs[3] = '{pix: 32'h0000_0001, mean: 24'h010100, scale: 24'h818080, exp: 24'hFF0001};
        vecs[4] = '{pix: 32'hAB10_2030, mean: 24'h101010, scale: 24'h404040, exp: 24'h000408};
        vecs[5] = '{pix: 32'h5A00_0010, mean: 24'h000080, scale: 24'h000010, exp: 24'h0000F9};

        reset     = 1'b1;
        start     = 1'b0;
        rows      = '0;
        cols      = '0;
        cfg_mean  = '0;
        cfg_scale = '0;
        m_mean    = '0;
        m_scale   = '0;
        last_wr_dat = '0;

        // Reset state
        settle(3);
        check("rst_busy",      {31'b0, busy},          32'd0);
        check("rst_done",      {31'b0, done},          32'd0);
        check("rst_in_read",   {31'b0, bus.in_read},   32'd0);
        check("rst_out_write", {31'b0, bus.out_write}, 32'd0);
        check("rst_out_din",   {8'h0, bus.out_din},    32'd0);
        @(negedge clk);
        reset = 1'b0;
        settle(2);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // 2x2 frame of one pixel, unstalled: done follows the 4th write by one cycle
        for (int i = 0; i < 4; i++) src_q.push_back(32'h0080_6040);
        run_frame(2, 2, 24'h000000, 24'h010101, "ident");
        check("ident_out", {8'h0, last_wr_dat}, 32'h010000);
        check("ident_done_timing", done_cyc, last_wr_cyc + 1);

        // Hand-computed arithmetic vectors, one 1x1 frame each
        for (int i = 0; i < 6; i++) begin
            src_q.push_back(vecs[i].pix);
            run_frame(1, 1, vecs[i].mean, vecs[i].scale, "vec");
            check($sformatf("vec%0d_out", i), {8'h0, last_wr_dat}, {8'h0, vecs[i].exp});
        end

        // Backpressure: sink toggles every 3 cycles, source never empty
        full_mode = 2;
        for (int i = 0; i < 8; i++) src_q.push_back($urandom());
        run_frame(1, 8, 24'($urandom()), 24'($urandom()), "bp");
        full_mode = 0;

        // Empty frame: done one cycle after start, no pops even with data waiting
        src_q.push_back(32'h0012_3456);
        p0 = pops;
        d0 = done_cnt;
        start_frame(0, 5, 24'h0, 24'h010101);
        wait_done(d0, 20);
        settle(2);
        check("zero_done_timing", done_cyc, start_cyc + 1);
        check("zero_pops", pops - p0, 0);
        check("zero_dones", done_cnt - d0, 1);
        src_q.delete();

        // Start pulses while running and while in DONE are ignored
        full_mode = 1;
        for (int i = 0; i < 6; i++) src_q.push_back($urandom());
        p0 = pops;
        w0 = writes;
        d0 = done_cnt;
        start_frame(2, 3, 24'h102030, 24'h405060);
        settle(2);
        check("ign_busy_at_pulse", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rows      = DIM_W'(7);
        cols      = DIM_W'(7);
        cfg_mean  = 24'hEFDFCF;
        cfg_scale = 24'hFFFFFF;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done(d0, 4000);
        // Still in the DONE cycle here: a start now must also be dropped.
        rows  = DIM_W'(3);
        cols  = DIM_W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        settle(4);
        check("ign_pops",   pops - p0,     6);
        check("ign_writes", writes - w0,   6);
        check("ign_dones",  done_cnt - d0, 1);
        check("ign_idle",   {31'b0, busy}, 32'd0);
        full_mode = 0;

        // Reset after 3 of 16 pixels, then a clean 1x1 frame
        for (int i = 0; i < 16; i++) src_q.push_back($urandom());
        start_frame(4, 4, 24'h000000, 24'h020202);
        p0 = pops;
        k  = 0;
        while (pops - p0 < 3 && k < 100) begin
            settle(1);
            k++;
        end
        if (pops - p0 < 3) fail("rst_mid_no_progress");
        @(negedge clk);
        reset = 1'b1;
        settle(1);
        w0 = writes;
        check("rstmid_busy",      {31'b0, busy},          32'd0);
        check("rstmid_in_read",   {31'b0, bus.in_read},   32'd0);
        check("rstmid_out_write", {31'b0, bus.out_write}, 32'd0);
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        settle(6);
        check("rstmid_no_writes", writes - w0, 0);
        check("rstmid_idle", {31'b0, busy}, 32'd0);
        src_q.push_back(32'h0033_2211);
        run_frame(1, 1, 24'h010203, 24'h808080, "post_rst");

        // Randomised frames with source gaps and sink stalls
        empty_mode = 1;
        full_mode  = 1;
        for (int f = 0; f < 8; f++) begin
            int r;
            int c;
            r = $urandom_range(1, 4);
            c = $urandom_range(1, 6);
            for (int i = 0; i < r * c; i++) src_q.push_back($urandom());
            run_frame(r, c, 24'($urandom()), 24'($urandom()), "rand");
        end
        empty_mode = 0;
        full_mode  = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
